// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the gapless BCD frequency counter.
// Holds the converter state encoding and the helpers that size the edge counter.
package freq_counter_pkg;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_DONE  = 2'd2
   } conv_state_e;

   // Shift cycles plus load and done leave headroom before the next window ends.
   localparam int MIN_PERIOD_OFFSET = 4;

   function automatic int count_bits_for(input int digits);
      int max_plus_one = 1;
      for (int i = 0; i < digits; i++) begin
         max_plus_one = max_plus_one * 10;
      end
      return $clog2(max_plus_one);
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one binary bit per cycle, then a one-cycle
// DONE state that registers the result and pulses valid.
module bin2bcd_serial
   import freq_counter_pkg::*;
#(
   parameter int DIGITS     = 3,
   parameter int COUNT_BITS = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [COUNT_BITS-1:0] bin,
   input  logic                  sat_in,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic                  valid
);

   localparam int SR_BITS  = 4*DIGITS + COUNT_BITS;
   localparam int CNT_BITS = $clog2(COUNT_BITS + 1);

   conv_state_e          state_q;
   logic [SR_BITS-1:0]   sr_q;
   logic [SR_BITS-1:0]   sr_shifted;
   logic [4*DIGITS-1:0]  nib_adj;
   logic [CNT_BITS-1:0]  bit_cnt_q;
   logic                 sat_q;
   logic [4*DIGITS-1:0]  bcd_q;
   logic                 ovf_q;
   logic                 valid_q;

   // Add-3 correction on every BCD nibble before the shift.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = sr_q[COUNT_BITS + 4*gi +: 4];
         assign nib_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate

   assign sr_shifted = {nib_adj, sr_q[COUNT_BITS-1:0]} << 1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= CONV_IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         sat_q     <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            CONV_IDLE: begin
               if (start) begin
                  sr_q      <= {{(4*DIGITS){1'b0}}, bin};
                  sat_q     <= sat_in;
                  bit_cnt_q <= '0;
                  state_q   <= CONV_SHIFT;
               end
            end
            CONV_SHIFT: begin
               sr_q      <= sr_shifted;
               bit_cnt_q <= bit_cnt_q + CNT_BITS'(1);
               if (bit_cnt_q == CNT_BITS'(COUNT_BITS - 1)) begin
                  state_q <= CONV_DONE;
               end
            end
            CONV_DONE: begin
               bcd_q   <= sr_q[SR_BITS-1 -: 4*DIGITS];
               ovf_q   <= sat_q;
               valid_q <= 1'b1;
               state_q <= CONV_IDLE;
            end
            default: state_q <= CONV_IDLE;
         endcase
      end
   end

   assign bcd      = bcd_q;
   assign overflow = ovf_q;
   assign valid    = valid_q;

   // The minimum gate period keeps a new window from ending mid-conversion.
   start_only_when_idle_a: assert property (
      @(posedge clk) disable iff (!reset_n) start |-> state_q == CONV_IDLE);

endmodule

// File: rtl/freq_counter_bcd.sv
// Gapless frequency counter: synchronised edge detect, gate window, saturating
// edge count and programmable period, feeding the serial BCD converter.
module freq_counter_bcd
   import freq_counter_pkg::*;
#(
   parameter int DIGITS         = 3,
   parameter int PERIOD_BITS    = 16,
   parameter int DEFAULT_PERIOD = 1200
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   signal,
   input  logic [PERIOD_BITS-1:0] period,
   input  logic                   period_load,
   output logic [4*DIGITS-1:0]    bcd,
   output logic                   valid,
   output logic                   overflow
);

   localparam int COUNT_BITS = count_bits_for(DIGITS);
   localparam int MIN_PERIOD = COUNT_BITS + MIN_PERIOD_OFFSET;
   localparam logic [COUNT_BITS-1:0]  MAX_COUNT = COUNT_BITS'(10**DIGITS - 1);
   localparam logic [PERIOD_BITS-1:0] MIN_P     = PERIOD_BITS'(MIN_PERIOD);

   logic                   sync1_q, sync2_q, sync_prev_q, edge_pulse_q;
   logic [PERIOD_BITS-1:0] win_cnt_q, win_cnt_d;
   logic [PERIOD_BITS-1:0] cur_period_q, cur_period_d;
   logic [PERIOD_BITS-1:0] pend_period_q, pend_period_d;
   logic [COUNT_BITS-1:0]  edge_cnt_q, edge_cnt_d;
   logic                   sat_q, sat_d;
   logic                   win_last;
   logic                   at_max;
   logic [COUNT_BITS-1:0]  cnt_total;
   logic                   sat_total;

   always_comb begin
      win_last  = (win_cnt_q == cur_period_q - PERIOD_BITS'(1));
      at_max    = (edge_cnt_q == MAX_COUNT);
      // Totals include this cycle's edge so the last-cycle edge lands in the ending window.
      cnt_total = (edge_pulse_q && !at_max) ? edge_cnt_q + COUNT_BITS'(1) : edge_cnt_q;
      sat_total = sat_q | (edge_pulse_q & at_max);

      pend_period_d = pend_period_q;
      if (period_load) begin
         pend_period_d = (period < MIN_P) ? MIN_P : period;
      end

      if (win_last) begin
         win_cnt_d    = '0;
         edge_cnt_d   = '0;
         sat_d        = 1'b0;
         cur_period_d = pend_period_q;
      end else begin
         win_cnt_d    = win_cnt_q + PERIOD_BITS'(1);
         edge_cnt_d   = cnt_total;
         sat_d        = sat_total;
         cur_period_d = cur_period_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         sync_prev_q   <= 1'b0;
         edge_pulse_q  <= 1'b0;
         win_cnt_q     <= '0;
         edge_cnt_q    <= '0;
         sat_q         <= 1'b0;
         cur_period_q  <= PERIOD_BITS'(DEFAULT_PERIOD);
         pend_period_q <= PERIOD_BITS'(DEFAULT_PERIOD);
      end else begin
         sync1_q       <= signal;
         sync2_q       <= sync1_q;
         sync_prev_q   <= sync2_q;
         edge_pulse_q  <= sync2_q & ~sync_prev_q;
         win_cnt_q     <= win_cnt_d;
         edge_cnt_q    <= edge_cnt_d;
         sat_q         <= sat_d;
         cur_period_q  <= cur_period_d;
         pend_period_q <= pend_period_d;
      end
   end

   bin2bcd_serial #(
      .DIGITS     (DIGITS),
      .COUNT_BITS (COUNT_BITS)
   ) u_conv (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (win_last),
      .bin      (cnt_total),
      .sat_in   (sat_total),
      .bcd      (bcd),
      .overflow (overflow),
      .valid    (valid)
   );

endmodule

// File: tb/tb_freq_counter_bcd.sv
// Randomised bench for freq_counter_bcd: records every input rise and period load,
// then derives each window's expected report from window arithmetic.
module tb_freq_counter_bcd;

   localparam int MIN_PER = 14;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        signal = 1'b0;
   logic [15:0] period = '0;
   logic        period_load = 1'b0;
   logic [11:0] bcd;
   logic        valid;
   logic        overflow;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int rel_cyc = 0;

   int          rise_q[$];
   int          load_cyc_q[$];
   int          load_val_q[$];
   int          v_cyc_q[$];
   logic [11:0] v_bcd_q[$];
   logic        v_ovf_q[$];
   int          e_cyc_q[$];
   int          e_cnt_q[$];

   freq_counter_bcd #(
      .DIGITS         (3),
      .PERIOD_BITS    (16),
      .DEFAULT_PERIOD (1200)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .signal      (signal),
      .period      (period),
      .period_load (period_load),
      .bcd         (bcd),
      .valid       (valid),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n && valid) begin
         v_cyc_q.push_back(cyc);
         v_bcd_q.push_back(bcd);
         v_ovf_q.push_back(overflow);
         $display("  valid cycle %0d (+%0d) bcd %03h overflow %0b", cyc, cyc - rel_cyc, bcd, overflow);
      end
   end

   function automatic logic [11:0] to_bcd(input int n);
      int m = (n > 999) ? 999 : n;
      return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // Window i spans [s, s+len-1]; a rise driven in cycle k is seen as an edge in k+3.
   function automatic void build_expected(input int end_cyc);
      int s = rel_cyc;
      int cur = 1200;
      int pend = 1200;
      int li = 0;
      int t;
      int n;
      e_cyc_q.delete();
      e_cnt_q.delete();
      t = s + cur - 1;
      while (t + 12 < end_cyc) begin
         n = 0;
         foreach (rise_q[j]) if (rise_q[j] + 3 >= s && rise_q[j] + 3 <= t) n++;
         e_cyc_q.push_back(t + 12);
         e_cnt_q.push_back(n);
         while (li < load_cyc_q.size() && load_cyc_q[li] <= t - 1) begin
            pend = (load_val_q[li] < MIN_PER) ? MIN_PER : load_val_q[li];
            li++;
         end
         cur = pend;
         s = t + 1;
         t = s + cur - 1;
      end
   endfunction

   task automatic step(input logic lvl, input logic ld, input int val);
      @(posedge clk);
      #1;
      if (lvl && !signal) rise_q.push_back(cyc);
      signal = lvl;
      period_load = ld;
      period = 16'(val);
      if (ld) begin
         load_cyc_q.push_back(cyc);
         load_val_q.push_back(val);
      end
   endtask

   task automatic assert_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      period_load = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rel_cyc = cyc;
      rise_q.delete();
      load_cyc_q.delete();
      load_val_q.delete();
      v_cyc_q.delete();
      v_bcd_q.delete();
      v_ovf_q.delete();
      if (signal) rise_q.push_back(cyc);
   endtask

   task automatic test_reset();
      assert_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %03h want 000", bcd); end
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      release_reset();
   endtask

   task automatic test_default();
      int ph = $urandom_range(0, 19);
      int k = 0;
      assert_reset();
      release_reset();
      repeat (ph) step(1'b0, 1'b0, 0);
      while (cyc < rel_cyc + 3615) begin
         step((k % 20) < 10, 1'b0, 0);
         k++;
      end
      build_expected(cyc);
      checks++;
      if (v_cyc_q.size() != e_cyc_q.size()) begin errors++; $display("FAIL default_nvalid: got %0d want %0d", v_cyc_q.size(), e_cyc_q.size()); end
      foreach (e_cyc_q[i]) if (i < v_cyc_q.size()) begin
         checks++;
         if (v_cyc_q[i] != e_cyc_q[i] || v_bcd_q[i] !== to_bcd(e_cnt_q[i]) || v_ovf_q[i] !== (e_cnt_q[i] > 999)) begin
            errors++;
            $display("FAIL default_win%0d: got cyc %0d bcd %03h ovf %b want cyc %0d bcd %03h ovf %b", i, v_cyc_q[i], v_bcd_q[i], v_ovf_q[i], e_cyc_q[i], to_bcd(e_cnt_q[i]), e_cnt_q[i] > 999);
         end
         if (i >= 1) begin
            checks++;
            if (v_bcd_q[i] !== 12'h060 || v_ovf_q[i] !== 1'b0) begin errors++; $display("FAIL default_060_win%0d: got %03h ovf %b want 060 ovf 0", i, v_bcd_q[i], v_ovf_q[i]); end
         end
      end
   endtask

   task automatic test_gapless();
      int ph = $urandom_range(0, 6);
      int hi = $urandom_range(1, 6);
      int k = 0;
      int sum = 0;
      int d;
      assert_reset();
      release_reset();
      repeat (ph) step(1'b0, 1'b0, 0);
      while (cyc < rel_cyc + 13215) begin
         step((k % 7) < hi, 1'b0, 0);
         k++;
      end
      build_expected(cyc);
      checks++;
      if (v_cyc_q.size() != 11 || e_cyc_q.size() != 11) begin errors++; $display("FAIL gapless_nvalid: got %0d model %0d want 11", v_cyc_q.size(), e_cyc_q.size()); end
      foreach (e_cyc_q[i]) if (i < v_cyc_q.size()) begin
         checks++;
         if (v_cyc_q[i] != e_cyc_q[i] || v_bcd_q[i] !== to_bcd(e_cnt_q[i]) || v_ovf_q[i] !== (e_cnt_q[i] > 999)) begin
            errors++;
            $display("FAIL gapless_win%0d: got cyc %0d bcd %03h ovf %b want cyc %0d bcd %03h", i, v_cyc_q[i], v_bcd_q[i], v_ovf_q[i], e_cyc_q[i], to_bcd(e_cnt_q[i]));
         end
         if (i >= 1) begin
            d = 100 * int'(v_bcd_q[i][11:8]) + 10 * int'(v_bcd_q[i][7:4]) + int'(v_bcd_q[i][3:0]);
            sum += d;
            checks++;
            if (d < 171 || d > 172) begin errors++; $display("FAIL gapless_range_win%0d: got %0d want 171..172", i, d); end
         end
      end
      checks++;
      if (sum < 1713 || sum > 1715) begin errors++; $display("FAIL gapless_sum: got %0d want 1714 +-1", sum); end
   endtask

   task automatic test_overflow();
      int k = 0;
      assert_reset();
      release_reset();
      while (cyc < rel_cyc + 6425) begin
         if (cyc < rel_cyc + 5200) step((k % 2) == 0, k == 100 || k == 1300, (k == 100) ? 4000 : 1200);
         else step((k % 20) < 10, 1'b0, 0);
         k++;
      end
      build_expected(cyc);
      checks++;
      if (v_cyc_q.size() != e_cyc_q.size()) begin errors++; $display("FAIL ovf_nvalid: got %0d want %0d", v_cyc_q.size(), e_cyc_q.size()); end
      foreach (e_cyc_q[i]) if (i < v_cyc_q.size()) begin
         checks++;
         if (v_cyc_q[i] != e_cyc_q[i] || v_bcd_q[i] !== to_bcd(e_cnt_q[i]) || v_ovf_q[i] !== (e_cnt_q[i] > 999)) begin
            errors++;
            $display("FAIL ovf_win%0d: got cyc %0d bcd %03h ovf %b want cyc %0d bcd %03h ovf %b", i, v_cyc_q[i], v_bcd_q[i], v_ovf_q[i], e_cyc_q[i], to_bcd(e_cnt_q[i]), e_cnt_q[i] > 999);
         end
      end
      checks++;
      if (v_cyc_q.size() >= 3) begin
         if (v_cyc_q[0] != rel_cyc + 1211 || v_bcd_q[1] !== 12'h999 || v_ovf_q[1] !== 1'b1 || v_ovf_q[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sequence: got cyc0 +%0d bcd1 %03h ovf1 %b ovf2 %b want +1211 999 1 0", v_cyc_q[0] - rel_cyc, v_bcd_q[1], v_ovf_q[1], v_ovf_q[2]);
         end
      end else begin
         errors++;
         $display("FAIL ovf_sequence: got %0d valids want 3", v_cyc_q.size());
      end
   endtask

   task automatic test_clamp();
      int k = 0;
      assert_reset();
      release_reset();
      while (cyc < rel_cyc + 1200 + 14*20 + 13) begin
         step(1'($urandom_range(0, 1)), k == 50, 3);
         k++;
      end
      build_expected(cyc);
      checks++;
      if (v_cyc_q.size() != e_cyc_q.size()) begin errors++; $display("FAIL clamp_nvalid: got %0d want %0d", v_cyc_q.size(), e_cyc_q.size()); end
      foreach (e_cyc_q[i]) if (i < v_cyc_q.size()) begin
         checks++;
         if (v_cyc_q[i] != e_cyc_q[i] || v_bcd_q[i] !== to_bcd(e_cnt_q[i]) || v_ovf_q[i] !== (e_cnt_q[i] > 999)) begin
            errors++;
            $display("FAIL clamp_win%0d: got cyc %0d bcd %03h want cyc %0d bcd %03h", i, v_cyc_q[i], v_bcd_q[i], e_cyc_q[i], to_bcd(e_cnt_q[i]));
         end
         if (i >= 1) begin
            checks++;
            if (v_cyc_q[i] - v_cyc_q[i-1] != 14) begin errors++; $display("FAIL clamp_spacing%0d: got %0d want 14", i, v_cyc_q[i] - v_cyc_q[i-1]); end
         end
      end
   endtask

   task automatic test_reset_abort();
      assert_reset();
      release_reset();
      // Second window ends at +2399; its conversion is mid-shift at +2404.
      while (cyc < rel_cyc + 2403) step(1'($urandom_range(0, 1)), 1'b0, 0);
      assert_reset();
      #2;
      checks++;
      if (bcd !== 12'h000 || overflow !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL abort_in_reset: got bcd %03h ovf %b valid %b want 000 0 0", bcd, overflow, valid); end
      release_reset();
      repeat (20) step(1'b0, 1'b0, 0);
      checks++;
      if (v_cyc_q.size() != 0 || bcd !== 12'h000 || overflow !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %0d valids bcd %03h ovf %b want 0 000 0", v_cyc_q.size(), bcd, overflow); end
      while (cyc < rel_cyc + 1215) step(1'($urandom_range(0, 1)), 1'b0, 0);
      build_expected(cyc);
      checks++;
      if (v_cyc_q.size() != 1 || e_cyc_q.size() != 1) begin errors++; $display("FAIL abort_nvalid: got %0d model %0d want 1", v_cyc_q.size(), e_cyc_q.size()); end
      foreach (e_cyc_q[i]) if (i < v_cyc_q.size()) begin
         checks++;
         if (v_cyc_q[i] != e_cyc_q[i] || v_bcd_q[i] !== to_bcd(e_cnt_q[i]) || v_ovf_q[i] !== (e_cnt_q[i] > 999)) begin
            errors++;
            $display("FAIL abort_win%0d: got cyc %0d bcd %03h want cyc %0d bcd %03h", i, v_cyc_q[i], v_bcd_q[i], e_cyc_q[i], to_bcd(e_cnt_q[i]));
         end
      end
   endtask

   task automatic test_zero();
      int k = 0;
      step(1'b1, 1'b0, 0);
      assert_reset();
      release_reset();
      while (cyc < rel_cyc + 1200 + 200 + 15) begin
         step(1'b1, k == 10, 100);
         k++;
      end
      build_expected(cyc);
      checks++;
      if (v_cyc_q.size() != 3 || e_cyc_q.size() != 3) begin errors++; $display("FAIL zero_nvalid: got %0d model %0d want 3", v_cyc_q.size(), e_cyc_q.size()); end
      foreach (e_cyc_q[i]) if (i < v_cyc_q.size()) begin
         checks++;
         if (v_cyc_q[i] != e_cyc_q[i] || v_bcd_q[i] !== to_bcd(e_cnt_q[i]) || v_ovf_q[i] !== (e_cnt_q[i] > 999)) begin
            errors++;
            $display("FAIL zero_win%0d: got cyc %0d bcd %03h want cyc %0d bcd %03h", i, v_cyc_q[i], v_bcd_q[i], e_cyc_q[i], to_bcd(e_cnt_q[i]));
         end
         if (i >= 1) begin
            checks++;
            if (v_bcd_q[i] !== 12'h000 || v_ovf_q[i] !== 1'b0) begin errors++; $display("FAIL zero_value_win%0d: got %03h ovf %b want 000 0", i, v_bcd_q[i], v_ovf_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_gapless();
      test_overflow();
      test_clamp();
      test_reset_abort();
      test_zero();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_counter_bcd.md
# freq_counter_bcd

Parametrised, gapless frequency counter: counts rising edges of an asynchronous `signal` over a programmable gate window of `clk` cycles. It converts each window's count to packed BCD with a serial double-dabble converter and presents `DIGITS` decimal digits with a one-cycle `valid` strobe. It sits between the input pin and the display driver and replaces the fixed 2-digit, fixed-period counter. Counting continues uninterrupted while the previous window is being converted.

## Interface
- `DIGITS`, 3: number of BCD digits; max displayable count is 10^DIGITS-1.
- `PERIOD_BITS`, 16: width of the gate-period register.
- `DEFAULT_PERIOD`, 1200: gate period (in clk cycles) loaded at reset.
- Derived localparam `COUNT_BITS` = $clog2(10^DIGITS) (10 for `DIGITS`=3).
- Derived localparam `MIN_PERIOD` = `COUNT_BITS`+4.
- `clk`, in, 1: single clock; everything is synchronous to it.
- `reset_n`, in, 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `signal`, in, 1: asynchronous measured input.
- `period`, in, `PERIOD_BITS`: new gate period.
- `period_load`, in, 1: one-cycle strobe that captures `period`.
- `bcd`, out, 4*`DIGITS`: result; digit k is at `bcd[4k+3:4k]`, with digit 0 = units.
- `valid`, out, 1: one-cycle pulse when `bcd` and `overflow` update.
- `overflow`, out, 1: the result window saturated; held with `bcd`.

## Operation
- Input path: 2-FF synchroniser on `signal`, then a registered rising-edge detect producing `edge_pulse`.
- Window counter `win_cnt` runs 0..`cur_period`-1, then wraps to 0.
  - The cycle where `win_cnt`==`cur_period`-1 is the window's last cycle.
  - An `edge_pulse` in that cycle counts in the ending window.
- Edge counter `edge_cnt` (`COUNT_BITS` wide) increments on `edge_pulse` and saturates at 10^DIGITS-1.
  - A further edge while saturated sets a window-local `sat` flag.
- At the window's last cycle:
  - `edge_cnt` (including that cycle's edge) and `sat` are copied into the converter.
  - `edge_cnt` and `sat` restart from 0 on the next cycle. No edges are lost between windows.
- Period handling:
  - `period_load` writes `pend_period`.
  - `cur_period` takes `pend_period` only at a window boundary; the current window is never truncated.
  - Loaded values below `MIN_PERIOD` are clamped to `MIN_PERIOD`.
  - A second load within one window overwrites the first.
- Converter FSM (sub-module): IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: waits for `start`.
  - SHIFT: runs `COUNT_BITS` cycles. Each cycle it first adds 3 to every BCD nibble >=5, then shifts left one bit from the binary MSB.
  - DONE: one cycle. It registers `bcd` and `overflow`(=`sat`) and pulses `valid`.
- `MIN_PERIOD` guarantees the converter is back in IDLE before the next `start`.
  - A `start` arriving in a non-IDLE state is ignored; this is unreachable by design and should be covered by an assertion.

## Timing
- Reset values: `bcd`=0, `valid`=0, `overflow`=0.
- Internal reset values: `win_cnt`=0, `edge_cnt`=0, `cur_period`=`pend_period`=`DEFAULT_PERIOD`, FSM=IDLE, synchroniser=0.
- The first window starts on the first clk after `reset_n` deasserts.
- Reset during any state aborts conversion immediately; no `valid` is emitted for the aborted window.
- Input latency: a `signal` rise reaches `edge_pulse` 3 clk edges later. Pulses shorter than one clk period may be missed.
- Output latency: with window last cycle T, `valid`=1 in cycle T+`COUNT_BITS`+2, and `bcd` is stable from that cycle until the next `valid`.
- `valid` repeats every `cur_period` cycles.
- Maximum countable rate is clk/2. Edge counts for a window are exact within ±1 at the window boundaries.

## Structure
- Package `freq_counter_pkg`:
  - converter state encoding (IDLE/SHIFT/DONE);
  - function computing `COUNT_BITS` from `DIGITS`;
  - `MIN_PERIOD` offset constant.
- Sub-module `bin2bcd_serial #(DIGITS, COUNT_BITS)`:
  - ports `clk`, `reset_n`, `start`, `bin`, `sat_in`, `bcd`, `overflow`, `valid`;
  - contains the FSM and the double-dabble shift register.
- The top level holds the synchroniser, edge detect, window/edge counters and period registers.

## Test plan
- Default period 1200, `signal` period 20 clk -> each `valid` shows `bcd`=12'h060, `overflow`=0.
- Window gaplessness: `signal` period 7 clk over 10 consecutive windows.
  - Expect 171 or 172 per window.
  - Expect the sum over 10 windows = floor(12000/7)±1.
- `period_load`=4000, `signal` toggling every clk (edge every 2 clk):
  - the current window completes at 1200 cycles;
  - the next window reports `bcd`=12'h999, `overflow`=1;
  - a later slow window clears `overflow` to 0.
- `period_load`=3 -> clamped to 14. `valid` pulses every 14 cycles, with each pulse 12 cycles after its window's last cycle.
- `reset_n` low for 1 cycle during SHIFT:
  - no `valid` for that window;
  - outputs read 0;
  - the next window after reset reports a correct count.
- Zero edges (`signal` held high) -> `bcd`=0, `overflow`=0, `valid` still pulses once per window.
